// File: rtl/program_sequencer_stack.sv
// program_sequencer_stack
//   Program sequencer for the MPU341 core. Each cycle it works out the next
//   program-memory address from the registered pc and the decoder controls.
//   It supports jumps, conditional jumps, and subroutine call/return through a
//   small LIFO return-address stack. A hold input stalls the sequencer.
//   Overflow and underflow of the stack set sticky flags.
//
// Ports
//   clk             system clock, rising edge
//   reset_n         asynchronous reset, active low
//   sync_reset      synchronous restart to address 0; also clears stack and flags
//   hold            stall: re-issue current pc, freeze all state
//   jmp             unconditional jump to target
//   jmp_nz          conditional jump, suppressed when dont_jmp is high
//   dont_jmp        zero flag from the datapath
//   call            push pc+1 and jump to target
//   ret             pop return address into pc
//   jmp_addr        target field; target = {jmp_addr, zeros}
//   pm_addr         next program-memory address (combinational, 0 in reset)
//   pc              registered current address
//   stack_level     number of occupied stack entries
//   stack_overflow  sticky: call seen with the stack full
//   stack_underflow sticky: ret seen with the stack empty
module program_sequencer_stack #(
  parameter int ADDR_W      = 8,
  parameter int JMP_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sync_reset,
  input  logic                             hold,
  input  logic                             jmp,
  input  logic                             jmp_nz,
  input  logic                             dont_jmp,
  input  logic                             call,
  input  logic                             ret,
  input  logic [JMP_W-1:0]                 jmp_addr,
  output logic [ADDR_W-1:0]                pm_addr,
  output logic [ADDR_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LVL_W-1:0]  sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign target   = ADDR_W'(jmp_addr) << (ADDR_W - JMP_W);
  // Indices are only used when sp is in range (push: sp<DEPTH, pop: sp>0).
  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - LVL_W'(1));

  always_comb begin
    pc_d    = pc_inc;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (sync_reset) begin
      pc_d  = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (hold) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (sp_q != '0) begin
        pc_d = stack_q[top_idx];
        sp_d = sp_q - LVL_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      pc_d = target;
      if (sp_q < DEPTH_L) begin
        push_en = 1'b1;
        sp_d    = sp_q + LVL_W'(1);
      end else begin
        // Full stack: the jump still happens, the return address is lost.
        ovf_d = 1'b1;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pc_d = target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents need no reset: sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pm_addr         = reset_n ? pc_d : '0;
  assign pc              = pc_q;
  assign stack_level     = sp_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
module tb_program_sequencer_stack;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic       hold = 1'b0;
  logic       jmp = 1'b0;
  logic       jmp_nz = 1'b0;
  logic       dont_jmp = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [3:0] jmp_addr = 4'h0;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [2:0] stack_level;
  logic       stack_overflow;
  logic       stack_underflow;

  program_sequencer_stack #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .hold(hold),
    .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret),
    .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc), .stack_level(stack_level),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pm;
    int pc;
    int lvl;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_id = 0;

  // Reference model: pc as an integer, return stack as a queue.
  int pc_m = 0;
  int stk_m[$];
  bit ovf_m = 0;
  bit unf_m = 0;

  task automatic model_step(input bit sr, h, j, jnz, dj, c, r, input int a, output int pm);
    int t;
    int inc;
    t   = a * 16;
    inc = (pc_m + 1) % 256;
    if (sr) begin
      pm = 0;
      stk_m.delete();
      ovf_m = 0;
      unf_m = 0;
    end else if (h) begin
      pm = pc_m;
    end else if (r) begin
      if (stk_m.size() > 0) pm = stk_m.pop_back();
      else begin
        pm = inc;
        unf_m = 1;
      end
    end else if (c) begin
      pm = t;
      if (stk_m.size() < DEPTH) stk_m.push_back(inc);
      else ovf_m = 1;
    end else if (j || (jnz && !dj)) begin
      pm = t;
    end else begin
      pm = inc;
    end
    pc_m = pm;
  endtask

  task automatic drive(input bit sr, h, j, jnz, dj, c, r, input int a);
    sync_reset = sr; hold = h; jmp = j; jmp_nz = jnz; dont_jmp = dj;
    call = c; ret = r; jmp_addr = 4'(a);
  endtask

  task automatic cyc(input bit sr, h, j, jnz, dj, c, r, input int a);
    exp_t e;
    int pm;
    @(posedge clk);
    #1;
    drive(sr, h, j, jnz, dj, c, r, a);
    e.id  = cyc_id;
    e.pc  = pc_m;
    e.lvl = stk_m.size();
    e.ovf = ovf_m;
    e.unf = unf_m;
    model_step(sr, h, j, jnz, dj, c, r, a, pm);
    e.pm  = pm;
    exp_q.push_back(e);
    cyc_id++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset_n between edges while the given controls are applied;
  // everything must read zero immediately, then the cycle completes idle.
  task automatic reset_pulse(input bit c, r, input int a);
    exp_t e;
    int pm;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, c, r, a);
    #1;
    reset_n = 1'b0;
    pc_m = 0;
    stk_m.delete();
    ovf_m = 0;
    unf_m = 0;
    e.id = cyc_id; e.pm = 0; e.pc = 0; e.lvl = 0; e.ovf = 0; e.unf = 0;
    exp_q.push_back(e);
    cyc_id++;
    @(negedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    model_step(0, 0, 0, 0, 0, 0, 0, 0, pm);
  endtask

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pm_addr", e.id, int'(pm_addr), e.pm);
      chk("pc", e.id, int'(pc), e.pc);
      chk("stack_level", e.id, int'(stack_level), e.lvl);
      chk("stack_overflow", e.id, int'(stack_overflow), int'(e.ovf));
      chk("stack_underflow", e.id, int'(stack_underflow), int'(e.unf));
    end
  end

  initial begin
    // 1: reset, sequential count, wrap at FF
    repeat (2) @(posedge clk);
    reset_pulse(0, 0, 0);
    idle(4);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'hF);
    idle(18);
    // 2: jumps
    cyc(0, 0, 1, 0, 0, 0, 0, 4'hA);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'h1);
    cyc(0, 0, 0, 1, 1, 0, 0, 4'h7);
    // 3: call from 12, ret from 34
    cyc(0, 0, 1, 0, 0, 0, 0, 4'h1);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 0, 4'h3);
    idle(4);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // 4: five nested calls, overflow, four rets
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    for (int i = 3; i <= 7; i++) cyc(0, 0, 0, 0, 0, 1, 0, i);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // 5: underflow, sticky flags, sync_reset clears
    cyc(0, 0, 1, 0, 0, 0, 0, 4'h2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // priority corner cases: call+jmp, ret+call, sync_reset over hold
    cyc(0, 0, 1, 0, 0, 1, 0, 4'h9);
    cyc(0, 0, 0, 0, 0, 1, 1, 4'hB);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // 6: hold over jmp at 07, then reset mid-call
    cyc(0, 0, 1, 0, 0, 0, 0, 4'h0);
    idle(7);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0, 4'hC);
    cyc(0, 0, 0, 0, 0, 1, 0, 4'h4);
    cyc(0, 0, 0, 0, 0, 1, 0, 4'h5);
    reset_pulse(1, 0, 4'h6);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 0, 4'h2);
    reset_pulse(0, 1, 0);
    idle(1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end else begin
        cyc($urandom_range(0, 40) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 15)));
      end
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
